ps2_event_fifo: RTL and testbench

Parametrised successor to the single-register key capture stage. Sits between ps2_rx (rx_done_tick/dout) and display or consumer logic. Decodes full PS/2 set-2 byte sequences: plain make, E0-extended, F0 break, E0 F0 extended break, and the E1 Pause sequence. Queues each decoded key event in a first-word-fall-through FIFO of configurable depth, so no keystroke is lost while the consumer is busy.

---
 rtl/ps2_event_fifo.sv | 168 ++++++++++++++++
 tb/tb_ps2_event_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_event_fifo.sv
// PS/2 set-2 scan-byte decoder feeding a first-word-fall-through event FIFO.
// States: IDLE | waiting for a new sequence
//         EXT  | E0 prefix seen, next byte is an extended code
//         BRK  | F0 seen (ext_flag tells whether E0 preceded it)
//         SKIP | discarding the tail of the E1 Pause sequence
module ps2_event_fifo #(
    parameter int          DEPTH        = 8,
    parameter int          AW           = 3,
    parameter bit          REPORT_BREAK = 1'b1,
    parameter int unsigned TIMEOUT_CYC  = 2500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic          ev_valid,
    output logic [7:0]    ev_code,
    output logic          ev_ext,
    output logic          ev_brk,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_SKIP} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [31:0] TMO_LIM  = TIMEOUT_CYC;
    localparam logic [7:0]  B_E0     = 8'hE0;
    localparam logic [7:0]  B_F0     = 8'hF0;
    localparam logic [7:0]  B_E1     = 8'hE1;

    state_t        state, state_nxt, cur;
    logic          ext_flag, ext_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic [31:0]   tmo_cnt;
    logic          timeout_hit, is_prefix, as_idle;
    logic          push;
    logic [9:0]    push_word;

    assign is_prefix = (rx_data == B_E0) || (rx_data == B_F0) || (rx_data == B_E1);

    always_comb begin
        state_nxt   = state;
        ext_nxt     = ext_flag;
        skip_nxt    = skip_cnt;
        push        = 1'b0;
        push_word   = '0;
        cur         = state;
        timeout_hit = (TMO_LIM != 32'd0) && (state != S_IDLE) && (tmo_cnt >= TMO_LIM);
        if (timeout_hit) begin
            cur       = S_IDLE;
            state_nxt = S_IDLE;
            ext_nxt   = 1'b0;
            skip_nxt  = '0;
        end
        // Prefix bytes that break the current sequence restart decoding from IDLE
        as_idle = (cur == S_IDLE) || ((cur == S_EXT) && (rx_data == B_E1))
                  || ((cur == S_BRK) && is_prefix);
        if (rx_done_tick) begin
            if (as_idle) begin
                state_nxt = S_IDLE;
                ext_nxt   = 1'b0;
                case (rx_data)
                    B_E0: state_nxt = S_EXT;
                    B_F0: state_nxt = S_BRK;
                    B_E1: begin
                        push      = 1'b1;
                        push_word = {1'b1, 1'b0, B_E1};
                        skip_nxt  = 3'd7;
                        state_nxt = S_SKIP;
                    end
                    8'h00, 8'hFF: ;
                    default: begin
                        push      = 1'b1;
                        push_word = {2'b00, rx_data};
                    end
                endcase
            end else begin
                case (cur)
                    S_EXT: begin
                        if (rx_data == B_F0) begin
                            state_nxt = S_BRK;
                            ext_nxt   = 1'b1;
                        end else if (rx_data != B_E0) begin
                            push      = 1'b1;
                            push_word = {2'b10, rx_data};
                            state_nxt = S_IDLE;
                            ext_nxt   = 1'b0;
                        end
                    end
                    S_BRK: begin
                        push      = REPORT_BREAK;
                        push_word = {ext_flag, 1'b1, rx_data};
                        state_nxt = S_IDLE;
                        ext_nxt   = 1'b0;
                    end
                    S_SKIP: begin
                        skip_nxt = (skip_cnt == 3'd0) ? 3'd0 : skip_cnt - 3'd1;
                        if (skip_cnt <= 3'd1) state_nxt = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ext_flag <= 1'b0;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            ext_flag <= ext_nxt;
            skip_cnt <= skip_nxt;
            if (rx_done_tick)
                tmo_cnt <= '0;
            else if (tmo_cnt < TMO_LIM)
                tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic          pop, full, wr_ok, drop;
    logic [AW:0]   remain;

    assign ev_valid   = (count != '0);
    assign pop        = rd_en && ev_valid;
    assign full       = (count == FULL_CNT);
    assign wr_ok      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign remain     = count - (AW+1)'(pop);
    assign rd_ptr_nxt = rd_ptr + AW'(pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_word;
    end

    // Head fields are registered so they hold their last value once the FIFO drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ev_code  <= '0;
            ev_ext   <= 1'b0;
            ev_brk   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
            if (remain != '0)
                {ev_ext, ev_brk, ev_code} <= mem[rd_ptr_nxt];
            else if (wr_ok)
                {ev_ext, ev_brk, ev_code} <= push_word;
        end
    end

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Bench for ps2_event_fifo: two instances (breaks reported / discarded) checked
// every cycle against a prefix-queue decoder model and queue-based FIFO models.
module tb_ps2_event_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_done_tick = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rd_en = 1'b0;
    logic          clr_ovf = 1'b0;

    logic          ev_valid_a, ev_ext_a, ev_brk_a, overflow_a;
    logic [7:0]    ev_code_a;
    logic [AW:0]   count_a;
    logic          ev_valid_b, ev_ext_b, ev_brk_b, overflow_b;
    logic [7:0]    ev_code_b;
    logic [AW:0]   count_b;

    ps2_event_fifo #(.DEPTH(DEPTH), .AW(AW), .REPORT_BREAK(1'b1), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(ev_valid_a), .ev_code(ev_code_a),
        .ev_ext(ev_ext_a), .ev_brk(ev_brk_a), .count(count_a), .overflow(overflow_a));

    ps2_event_fifo #(.DEPTH(DEPTH), .AW(AW), .REPORT_BREAK(1'b0), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(ev_valid_b), .ev_code(ev_code_b),
        .ev_ext(ev_ext_b), .ev_brk(ev_brk_b), .count(count_b), .overflow(overflow_b));

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pre[$];
    int          skip = 0;
    int unsigned last_tick = 0;
    logic [9:0]  mq_a[$];
    logic [9:0]  mq_b[$];
    bit          ovf_a = 1'b0, ovf_b = 1'b0;
    logic [9:0]  last_a = '0, last_b = '0;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic bit has(input logic [7:0] v);
        foreach (pre[i]) if (pre[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pre.delete();
        skip = 0;
        mq_a.delete();
        mq_b.delete();
        ovf_a = 1'b0;
        ovf_b = 1'b0;
        last_a = '0;
        last_b = '0;
    endtask

    // Decode one byte from the pending-prefix list; E1 skips the 7-byte Pause tail
    task automatic decode(input logic [7:0] b, output bit push, output logic [9:0] w);
        int unsigned up;
        up = edge_n + 1;
        push = 1'b0;
        w = '0;
        if (up - last_tick > TMO) begin
            pre.delete();
            skip = 0;
        end
        last_tick = up;
        if (skip > 0) begin
            skip--;
        end else if (b == 8'hE1) begin
            push = 1'b1;
            w = {2'b10, b};
            skip = 7;
            pre.delete();
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (has(8'hF0)) begin
                pre.delete();
                pre.push_back(b);
            end else if (b == 8'hF0 || !has(8'hE0)) begin
                pre.push_back(b);
            end
        end else if (pre.size() == 0 && (b == 8'h00 || b == 8'hFF)) begin
            push = 1'b0;
        end else begin
            push = 1'b1;
            w = {has(8'hE0), has(8'hF0), b};
            pre.delete();
        end
    endtask

    task automatic fifo_model(inout logic [9:0] q[$], inout bit ovf, inout logic [9:0] last,
                              input bit push, input logic [9:0] w, input bit rd, input bit clr);
        bit pop, drop;
        pop  = rd && (q.size() > 0);
        drop = push && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(w);
        if (drop) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        if (q.size() > 0) last = q[0];
    endtask

    task automatic check_all(input string tag);
        chk(tag, "valid_a", 32'(ev_valid_a), 32'(mq_a.size() != 0));
        chk(tag, "head_a",  32'({ev_ext_a, ev_brk_a, ev_code_a}), 32'(last_a));
        chk(tag, "count_a", 32'(count_a), 32'(mq_a.size()));
        chk(tag, "ovf_a",   32'(overflow_a), 32'(ovf_a));
        chk(tag, "valid_b", 32'(ev_valid_b), 32'(mq_b.size() != 0));
        chk(tag, "head_b",  32'({ev_ext_b, ev_brk_b, ev_code_b}), 32'(last_b));
        chk(tag, "count_b", 32'(count_b), 32'(mq_b.size()));
        chk(tag, "ovf_b",   32'(overflow_b), 32'(ovf_b));
    endtask

    // Called at a falling edge; drives one cycle, then checks at the next falling edge
    task automatic step(input bit tick, input logic [7:0] b, input bit rd, input bit clr, input string tag);
        bit push;
        logic [9:0] w;
        rx_done_tick = tick;
        rx_data = b;
        rd_en = rd;
        clr_ovf = clr;
        push = 1'b0;
        w = '0;
        if (tick) decode(b, push, w);
        fifo_model(mq_a, ovf_a, last_a, push, w, rd, clr);
        fifo_model(mq_b, ovf_b, last_b, push && !w[8], w, rd, clr);
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_en = 1'b0;
        clr_ovf = 1'b0;
        check_all(tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        step(1'b1, b, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic pop_n(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        check_all(tag);
    endtask

    logic [7:0] pause_seq [9];

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_all("reset");

        send(8'h1C, "make");
        chk("make", "code", 32'(ev_code_a), 32'h1C);
        pop_n(1, "make_pop");
        send(8'hF0, "brk_f0");
        send(8'h1C, "brk");
        chk("brk", "brk_bit", 32'(ev_brk_a), 32'd1);
        pop_n(1, "brk_pop");
        chk("brk_pop", "count", 32'(count_a), 32'd0);

        send(8'hE0, "ext");
        send(8'h75, "ext");
        send(8'hE0, "ext");
        send(8'hF0, "ext");
        send(8'h75, "ext");
        chk("ext", "count_nb", 32'(count_b), 32'd1);
        pop_n(2, "ext_pop");

        foreach (pause_seq[i]) send(pause_seq[i], "pause");
        chk("pause", "count", 32'(count_a), 32'd2);
        pop_n(2, "pause_pop");

        for (int i = 0; i < 9; i++) send(8'(8'h10 + i), "ovf_fill");
        chk("ovf_fill", "count", 32'(count_a), 32'd8);
        chk("ovf_fill", "ovf", 32'(overflow_a), 32'd1);
        step(1'b1, 8'h19, 1'b1, 1'b0, "ovf_pushpop");
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
        chk("ovf_clr", "ovf", 32'(overflow_a), 32'd0);
        pop_n(9, "ovf_drain");

        send(8'hE0, "tmo");
        idle(TMO, "tmo_gap");
        send(8'h1C, "tmo");
        chk("tmo", "ext", 32'(ev_ext_a), 32'd0);
        pop_n(1, "tmo_pop");
        send(8'hF0, "tmo_brk");
        idle(TMO, "tmo_gap");
        send(8'h1C, "tmo_brk");
        chk("tmo_brk", "brk", 32'(ev_brk_a), 32'd0);
        pop_n(1, "tmo_pop");
        send(8'hE0, "tmo_edge");
        idle(TMO - 1, "tmo_gap");
        send(8'h75, "tmo_edge");
        chk("tmo_edge", "ext", 32'(ev_ext_a), 32'd1);
        pop_n(1, "tmo_pop");

        send(8'hE0, "rst_mid");
        send(8'hF0, "rst_mid");
        pulse_reset("rst_mid");
        send(8'h1C, "rst_mid");
        chk("rst_mid", "count", 32'(count_a), 32'd1);
        pop_n(1, "rst_pop");

        for (int i = 0; i < 800; i++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                3: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom_range(1, 254));
            endcase
            step($urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, "rand");
            if ($urandom_range(0, 59) == 0) idle($urandom_range(TMO - 5, TMO + 5), "rand_gap");
        end
        pop_n(DEPTH, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
